// File: rtl/bpu_pkg.sv
// Shared definitions for the set-associative branch target buffer.
//   - update op encodings (BPU_OP_*) and their width BPU_OP_NBIT
//   - clog2 for deriving index/way widths from parameters
//   - saturating helpers for direction counters up to 3 bits wide
package bpu_pkg;

    localparam int BPU_OP_NBIT  = 2;
    localparam int BPU_CNT_WMAX = 3;

    typedef enum logic [BPU_OP_NBIT-1:0] {
        BPU_OP_NOP      = 2'd0,
        BPU_OP_TAKEN    = 2'd1,
        BPU_OP_NOTTAKEN = 2'd2,
        BPU_OP_FLUSH    = 2'd3
    } bpu_op_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

    // Counters are carried in the widest legal width; callers cast back.
    function automatic logic [BPU_CNT_WMAX-1:0] cnt_inc(input logic [BPU_CNT_WMAX-1:0] c,
                                                         input int nbit);
        logic [BPU_CNT_WMAX-1:0] top;
        top = BPU_CNT_WMAX'((1 << nbit) - 1);
        return (c >= top) ? top : c + 3'd1;
    endfunction

    function automatic logic [BPU_CNT_WMAX-1:0] cnt_dec(input logic [BPU_CNT_WMAX-1:0] c);
        return (c == '0) ? c : c - 3'd1;
    endfunction

    // Weakly-taken value written on allocation.
    function automatic logic [BPU_CNT_WMAX-1:0] cnt_init(input int nbit);
        return BPU_CNT_WMAX'(1 << (nbit - 1));
    endfunction

endpackage

// File: rtl/syn_bpu_assoc_if.sv
// Bus between the pipeline and the branch target buffer.
//   en     : global pipeline enable (0 freezes all predictor state)
//   op     : update op from EX (NOP / TAKEN / NOTTAKEN / FLUSH)
//   pc_w   : EX branch pc, dst_w : EX resolved target
//   pc_r   : IF fetch pc; dst_r / take_r / hit_r : lookup result
// Protocol: there is no valid/ready pairing. A lookup is a pure combinational
// function of pc_r, answered in the same cycle. An update is presented for one
// cycle on op/pc_w/dst_w and is committed at the rising edge where en=1; the
// predictor can never stall, so the sender needs no acknowledge.
interface syn_bpu_assoc_if #(
    parameter int PC_NBIT = 10
);
    logic                          en;
    logic [bpu_pkg::BPU_OP_NBIT-1:0] op;
    logic [PC_NBIT-1:0]            pc_r;
    logic [PC_NBIT-1:0]            pc_w;
    logic [PC_NBIT-1:0]            dst_w;
    logic [PC_NBIT-1:0]            dst_r;
    logic                          take_r;
    logic                          hit_r;

    modport master (
        output en, op, pc_r, pc_w, dst_w,
        input  dst_r, take_r, hit_r
    );

    modport slave (
        input  en, op, pc_r, pc_w, dst_w,
        output dst_r, take_r, hit_r
    );
endinterface

// File: rtl/bpu_set.sv
// One set of the branch target buffer: WAYS entries (valid, tag, target,
// direction counter) plus a round-robin victim pointer.
//   clk, rst         : clock, synchronous active-high reset
//   en, op           : update enable and op (FLUSH clears every set)
//   upd_sel          : this set is the one addressed by pc_w
//   tag_w, dst_w     : update tag and resolved target
//   tag_r            : lookup tag
//   rd_hit, rd_cnt,
//   rd_dst           : pre-update lookup result (zeros on miss)
module bpu_set
    import bpu_pkg::*;
#(
    parameter int TAG_NBIT = 7,
    parameter int PC_NBIT  = 10,
    parameter int WAYS     = 2,
    parameter int CNT_NBIT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [BPU_OP_NBIT-1:0] op,
    input  logic                   upd_sel,
    input  logic [TAG_NBIT-1:0]    tag_w,
    input  logic [PC_NBIT-1:0]     dst_w,
    input  logic [TAG_NBIT-1:0]    tag_r,
    output logic                   rd_hit,
    output logic [CNT_NBIT-1:0]    rd_cnt,
    output logic [PC_NBIT-1:0]     rd_dst
);

    localparam int WAY_NBIT = (WAYS > 1) ? clog2(WAYS) : 1;

    logic                valid_q [WAYS];
    logic                valid_d [WAYS];
    logic [TAG_NBIT-1:0] tag_q   [WAYS];
    logic [TAG_NBIT-1:0] tag_d   [WAYS];
    logic [PC_NBIT-1:0]  dst_q   [WAYS];
    logic [PC_NBIT-1:0]  dst_d   [WAYS];
    logic [CNT_NBIT-1:0] cnt_q   [WAYS];
    logic [CNT_NBIT-1:0] cnt_d   [WAYS];
    logic [WAY_NBIT-1:0] vic_q;
    logic [WAY_NBIT-1:0] vic_d;

    logic                w_hit;
    logic [WAY_NBIT-1:0] w_way;
    logic                free_ok;
    logic [WAY_NBIT-1:0] free_way;
    logic [WAY_NBIT-1:0] alloc_way;

    // Scanning from the top way down lets the lowest-numbered way win.
    always_comb begin
        rd_hit = 1'b0;
        rd_cnt = '0;
        rd_dst = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == tag_r)) begin
                rd_hit = 1'b1;
                rd_cnt = cnt_q[i];
                rd_dst = dst_q[i];
            end
        end
    end

    always_comb begin
        w_hit    = 1'b0;
        w_way    = '0;
        free_ok  = 1'b0;
        free_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == tag_w)) begin
                w_hit = 1'b1;
                w_way = WAY_NBIT'(i);
            end
            if (!valid_q[i]) begin
                free_ok  = 1'b1;
                free_way = WAY_NBIT'(i);
            end
        end
    end

    assign alloc_way = free_ok ? free_way : vic_q;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        vic_d   = vic_q;
        if (en) begin
            if (op == BPU_OP_FLUSH) begin
                for (int i = 0; i < WAYS; i++) begin
                    valid_d[i] = 1'b0;
                    tag_d[i]   = '0;
                    dst_d[i]   = '0;
                    cnt_d[i]   = '0;
                end
                vic_d = '0;
            end else if (upd_sel && (op == BPU_OP_TAKEN)) begin
                if (w_hit) begin
                    cnt_d[w_way] = CNT_NBIT'(cnt_inc(BPU_CNT_WMAX'(cnt_q[w_way]), CNT_NBIT));
                    dst_d[w_way] = dst_w;
                end else begin
                    valid_d[alloc_way] = 1'b1;
                    tag_d[alloc_way]   = tag_w;
                    dst_d[alloc_way]   = dst_w;
                    cnt_d[alloc_way]   = CNT_NBIT'(cnt_init(CNT_NBIT));
                    // The pointer only moves when a valid entry is evicted.
                    if (!free_ok) begin
                        vic_d = (vic_q == WAY_NBIT'(WAYS - 1)) ? '0 : vic_q + WAY_NBIT'(1);
                    end
                end
            end else if (upd_sel && (op == BPU_OP_NOTTAKEN) && w_hit) begin
                cnt_d[w_way] = CNT_NBIT'(cnt_dec(BPU_CNT_WMAX'(cnt_q[w_way])));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WAYS; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                dst_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
            vic_q <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            vic_q   <= vic_d;
        end
    end

endmodule

// File: rtl/syn_bpu_assoc.sv
// Set-associative branch target buffer for the IF stage.
//   clk, rst : clock, synchronous active-high reset (wins over en and op)
//   bus      : syn_bpu_assoc_if.slave -- lookup (pc_r -> hit_r/take_r/dst_r,
//              combinational) and update (en/op/pc_w/dst_w, registered)
// Index is pc[log2(SETS)-1:0]; the remaining upper bits form the tag.
// Optional macro BPU_FWD_EN: bypasses a same-cycle update to the lookup when
// pc_w == pc_r, and makes an enabled FLUSH force a miss in the same cycle.
module syn_bpu_assoc
    import bpu_pkg::*;
#(
    parameter int PC_NBIT  = 10,
    parameter int SETS     = 8,
    parameter int WAYS     = 2,
    parameter int CNT_NBIT = 2
) (
    input  logic           clk,
    input  logic           rst,
    syn_bpu_assoc_if.slave bus
);

    localparam int IDX_NBIT = clog2(SETS);
    localparam int TAG_NBIT = PC_NBIT - IDX_NBIT;

    logic [IDX_NBIT-1:0] idx_r;
    logic [IDX_NBIT-1:0] idx_w;
    logic [TAG_NBIT-1:0] tag_r;
    logic [TAG_NBIT-1:0] tag_w;

    logic                set_hit [SETS];
    logic [CNT_NBIT-1:0] set_cnt [SETS];
    logic [PC_NBIT-1:0]  set_dst [SETS];

    logic                lk_hit;
    logic [CNT_NBIT-1:0] lk_cnt;
    logic [PC_NBIT-1:0]  lk_dst;

    logic                hit_n;
    logic [CNT_NBIT-1:0] cnt_n;
    logic [PC_NBIT-1:0]  dst_n;

    assign idx_r = bus.pc_r[IDX_NBIT-1:0];
    assign tag_r = bus.pc_r[PC_NBIT-1:IDX_NBIT];
    assign idx_w = bus.pc_w[IDX_NBIT-1:0];
    assign tag_w = bus.pc_w[PC_NBIT-1:IDX_NBIT];

    for (genvar s = 0; s < SETS; s++) begin : g_set
        bpu_set #(
            .TAG_NBIT (TAG_NBIT),
            .PC_NBIT  (PC_NBIT),
            .WAYS     (WAYS),
            .CNT_NBIT (CNT_NBIT)
        ) u_set (
            .clk     (clk),
            .rst     (rst),
            .en      (bus.en),
            .op      (bus.op),
            .upd_sel (idx_w == IDX_NBIT'(s)),
            .tag_w   (tag_w),
            .dst_w   (bus.dst_w),
            .tag_r   (tag_r),
            .rd_hit  (set_hit[s]),
            .rd_cnt  (set_cnt[s]),
            .rd_dst  (set_dst[s])
        );
    end

    assign lk_hit = set_hit[idx_r];
    assign lk_cnt = set_cnt[idx_r];
    assign lk_dst = set_dst[idx_r];

    always_comb begin
        hit_n = lk_hit;
        cnt_n = lk_cnt;
        dst_n = lk_dst;
`ifdef BPU_FWD_EN
        // With pc_w == pc_r the pre-update lookup already names the entry the
        // update will touch, so the post-update entry is derived from it.
        if (bus.en) begin
            if (bus.op == BPU_OP_FLUSH) begin
                hit_n = 1'b0;
                cnt_n = '0;
                dst_n = '0;
            end else if (bus.pc_w == bus.pc_r) begin
                if (bus.op == BPU_OP_TAKEN) begin
                    hit_n = 1'b1;
                    dst_n = bus.dst_w;
                    cnt_n = lk_hit ? CNT_NBIT'(cnt_inc(BPU_CNT_WMAX'(lk_cnt), CNT_NBIT))
                                   : CNT_NBIT'(cnt_init(CNT_NBIT));
                end else if ((bus.op == BPU_OP_NOTTAKEN) && lk_hit) begin
                    cnt_n = CNT_NBIT'(cnt_dec(BPU_CNT_WMAX'(lk_cnt)));
                end
            end
        end
`endif
    end

    // Counter MSB set is the same as counter >= the weakly-taken value.
    assign bus.hit_r  = hit_n;
    assign bus.take_r = hit_n && (cnt_n >= CNT_NBIT'(cnt_init(CNT_NBIT)));
    assign bus.dst_r  = dst_n;

endmodule

// File: tb/tb_syn_bpu_assoc.sv
module tb_syn_bpu_assoc;
    import bpu_pkg::*;

    localparam int PC_NBIT = 10;
    localparam int W       = PC_NBIT + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    syn_bpu_assoc_if #(.PC_NBIT(PC_NBIT)) bus ();

    syn_bpu_assoc #(
        .PC_NBIT  (PC_NBIT),
        .SETS     (8),
        .WAYS     (2),
        .CNT_NBIT (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst    = 1'b1;
        bus.op = BPU_OP_NOP;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_update(input logic [1:0] op, input logic [PC_NBIT-1:0] pc,
                             input logic [PC_NBIT-1:0] dst, input logic en_v);
        bus.en    = en_v;
        bus.op    = op;
        bus.pc_w  = pc;
        bus.dst_w = dst;
        @(posedge clk);
        #1;
        bus.op = BPU_OP_NOP;
        bus.en = 1'b1;
    endtask

    // Queues the expected lookup result and captures the DUT's at the falling edge.
    task automatic probe(input string nm, input logic [PC_NBIT-1:0] pc, input logic h,
                         input logic t, input logic [PC_NBIT-1:0] d);
        bus.pc_r = pc;
        exp_q.push_back({h, t, d});
        name_q.push_back(nm);
        @(negedge clk);
        obs_q.push_back({bus.hit_r, bus.take_r, bus.dst_r});
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [W-1:0] e, o;
        string n;
        do_reset();
        for (int p = 0; p < 1024; p++) probe("reset_sweep", PC_NBIT'(p), 1'b0, 1'b0, '0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got hit=%0b take=%0b dst=%h, expected hit=%0b take=%0b dst=%h",
                         n, o[W-1], o[W-2], o[PC_NBIT-1:0], e[W-1], e[W-2], e[PC_NBIT-1:0]);
            end
        end
    endtask

    task automatic test_counter();
        logic [W-1:0] e, o;
        string n;
        logic [PC_NBIT-1:0] rnd;
        rnd = PC_NBIT'($urandom_range(1, 1023));
        do_reset();
        do_update(BPU_OP_TAKEN, 10'h010, 10'h1A0, 1'b1);
        probe("alloc_weak_taken", 10'h010, 1'b1, 1'b1, 10'h1A0);
        do_update(BPU_OP_NOTTAKEN, 10'h010, 10'h000, 1'b1);
        probe("nt_once", 10'h010, 1'b1, 1'b0, 10'h1A0);
        do_update(BPU_OP_NOTTAKEN, 10'h010, 10'h000, 1'b1);
        probe("nt_twice", 10'h010, 1'b1, 1'b0, 10'h1A0);
        do_update(BPU_OP_TAKEN, 10'h010, 10'h1A0, 1'b1);
        probe("t_from_zero", 10'h010, 1'b1, 1'b0, 10'h1A0);
        do_update(BPU_OP_TAKEN, 10'h010, 10'h1A0, 1'b1);
        probe("t_to_two", 10'h010, 1'b1, 1'b1, 10'h1A0);
        do_update(BPU_OP_TAKEN, 10'h010, rnd, 1'b1);
        probe("t_to_three_overwrite", 10'h010, 1'b1, 1'b1, rnd);
        do_update(BPU_OP_TAKEN, 10'h010, rnd, 1'b1);
        probe("t_saturated", 10'h010, 1'b1, 1'b1, rnd);
        do_update(BPU_OP_NOTTAKEN, 10'h010, 10'h000, 1'b1);
        probe("nt_after_sat", 10'h010, 1'b1, 1'b1, rnd);
        do_update(BPU_OP_NOTTAKEN, 10'h010, 10'h000, 1'b1);
        probe("nt_to_one", 10'h010, 1'b1, 1'b0, rnd);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got hit=%0b take=%0b dst=%h, expected hit=%0b take=%0b dst=%h",
                         n, o[W-1], o[W-2], o[PC_NBIT-1:0], e[W-1], e[W-2], e[PC_NBIT-1:0]);
            end
        end
    endtask

    task automatic test_replacement();
        logic [W-1:0] e, o;
        string n;
        do_reset();
        do_update(BPU_OP_TAKEN, 10'h003, 10'h103, 1'b1);
        do_update(BPU_OP_TAKEN, 10'h00B, 10'h10B, 1'b1);
        do_update(BPU_OP_TAKEN, 10'h013, 10'h113, 1'b1);
        probe("evict_003", 10'h003, 1'b0, 1'b0, '0);
        probe("keep_00b", 10'h00B, 1'b1, 1'b1, 10'h10B);
        probe("new_013", 10'h013, 1'b1, 1'b1, 10'h113);
        // A hit must not move the victim pointer.
        do_update(BPU_OP_TAKEN, 10'h013, 10'h213, 1'b1);
        do_update(BPU_OP_TAKEN, 10'h01B, 10'h11B, 1'b1);
        probe("rr_evict_00b", 10'h00B, 1'b0, 1'b0, '0);
        probe("keep_013", 10'h013, 1'b1, 1'b1, 10'h213);
        probe("new_01b", 10'h01B, 1'b1, 1'b1, 10'h11B);
        do_update(BPU_OP_TAKEN, 10'h003, 10'h303, 1'b1);
        probe("rr_wrap_evict_013", 10'h013, 1'b0, 1'b0, '0);
        probe("keep_01b", 10'h01B, 1'b1, 1'b1, 10'h11B);
        probe("realloc_003", 10'h003, 1'b1, 1'b1, 10'h303);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got hit=%0b take=%0b dst=%h, expected hit=%0b take=%0b dst=%h",
                         n, o[W-1], o[W-2], o[PC_NBIT-1:0], e[W-1], e[W-2], e[PC_NBIT-1:0]);
            end
        end
    endtask

    task automatic test_enable_flush();
        logic [W-1:0] e, o;
        string n;
        do_reset();
        do_update(BPU_OP_NOTTAKEN, 10'h055, 10'h0AA, 1'b1);
        probe("nt_miss_no_alloc", 10'h055, 1'b0, 1'b0, '0);
        do_update(BPU_OP_TAKEN, 10'h020, 10'h0C0, 1'b0);
        probe("en0_no_alloc", 10'h020, 1'b0, 1'b0, '0);
        do_update(BPU_OP_TAKEN, 10'h020, 10'h0C0, 1'b1);
        do_update(BPU_OP_TAKEN, 10'h005, 10'h105, 1'b1);
        do_update(BPU_OP_TAKEN, 10'h00D, 10'h10D, 1'b1);
        do_update(BPU_OP_TAKEN, 10'h015, 10'h115, 1'b1);
        probe("alloc_020", 10'h020, 1'b1, 1'b1, 10'h0C0);
        do_update(BPU_OP_FLUSH, 10'h000, 10'h000, 1'b0);
        probe("en0_flush_frozen", 10'h020, 1'b1, 1'b1, 10'h0C0);
        do_update(BPU_OP_FLUSH, 10'h000, 10'h000, 1'b1);
        probe("flush_020", 10'h020, 1'b0, 1'b0, '0);
        probe("flush_015", 10'h015, 1'b0, 1'b0, '0);
        // Victim pointer must be back at way 0 after the flush.
        do_update(BPU_OP_TAKEN, 10'h005, 10'h205, 1'b1);
        do_update(BPU_OP_TAKEN, 10'h00D, 10'h20D, 1'b1);
        do_update(BPU_OP_TAKEN, 10'h015, 10'h215, 1'b1);
        probe("flush_vic_005", 10'h005, 1'b0, 1'b0, '0);
        probe("flush_vic_00d", 10'h00D, 1'b1, 1'b1, 10'h20D);
        probe("flush_vic_015", 10'h015, 1'b1, 1'b1, 10'h215);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got hit=%0b take=%0b dst=%h, expected hit=%0b take=%0b dst=%h",
                         n, o[W-1], o[W-2], o[PC_NBIT-1:0], e[W-1], e[W-2], e[PC_NBIT-1:0]);
            end
        end
    endtask

    task automatic test_same_cycle();
        logic [W-1:0] e, o;
        string n;
        do_reset();
        bus.en    = 1'b1;
        bus.op    = BPU_OP_TAKEN;
        bus.pc_w  = 10'h030;
        bus.dst_w = 10'h2C5;
`ifdef BPU_FWD_EN
        probe("rdw_same_cycle", 10'h030, 1'b1, 1'b1, 10'h2C5);
`else
        probe("rdw_same_cycle", 10'h030, 1'b0, 1'b0, '0);
`endif
        @(posedge clk);
        #1;
        bus.op = BPU_OP_NOP;
        probe("rdw_next_cycle", 10'h030, 1'b1, 1'b1, 10'h2C5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got hit=%0b take=%0b dst=%h, expected hit=%0b take=%0b dst=%h",
                         n, o[W-1], o[W-2], o[PC_NBIT-1:0], e[W-1], e[W-2], e[PC_NBIT-1:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e, o;
        string n;
        logic [PC_NBIT-1:0] d0, d1;
        d0 = PC_NBIT'($urandom_range(0, 1023));
        d1 = PC_NBIT'($urandom_range(0, 1023));
        do_reset();
        do_update(BPU_OP_TAKEN, 10'h061, d0, 1'b1);
        do_update(BPU_OP_TAKEN, 10'h062, d1, 1'b1);
        do_update(BPU_OP_TAKEN, 10'h064, 10'h3FF, 1'b1);
        do_update(BPU_OP_NOTTAKEN, 10'h064, 10'h000, 1'b1);
        probe("b2b_061", 10'h061, 1'b1, 1'b1, d0);
        probe("b2b_062", 10'h062, 1'b1, 1'b1, d1);
        probe("b2b_064_nt", 10'h064, 1'b1, 1'b0, 10'h3FF);
        probe("b2b_tag_differs", 10'h0E1, 1'b0, 1'b0, '0);
        // Reset on the same edge as a TAKEN update: reset wins.
        do_update(BPU_OP_TAKEN, 10'h040, 10'h140, 1'b1);
        rst       = 1'b1;
        bus.op    = BPU_OP_TAKEN;
        bus.pc_w  = 10'h041;
        bus.dst_w = 10'h141;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        bus.op = BPU_OP_NOP;
        probe("rst_wins_040", 10'h040, 1'b0, 1'b0, '0);
        probe("rst_wins_041", 10'h041, 1'b0, 1'b0, '0);
        probe("rst_wins_061", 10'h061, 1'b0, 1'b0, '0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got hit=%0b take=%0b dst=%h, expected hit=%0b take=%0b dst=%h",
                         n, o[W-1], o[W-2], o[PC_NBIT-1:0], e[W-1], e[W-2], e[PC_NBIT-1:0]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.en    = 1'b1;
        bus.op    = BPU_OP_NOP;
        bus.pc_r  = '0;
        bus.pc_w  = '0;
        bus.dst_w = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_counter();
        test_replacement();
        test_enable_flush();
        test_same_cycle();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
